// File: rtl/audio_sample_sched.sv
// Sample-rate scheduler: round-robin arbitration of two producers into a small
// FIFO, popped once per DIV-cycle period onto the modulator sample input.
module audio_sample_sched #(
    parameter int DIV     = 2267,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic               a_valid_i,
    input  logic [15:0]        a_data_i,
    output logic               a_ready_o,
    input  logic               b_valid_i,
    input  logic [15:0]        b_data_i,
    output logic               b_ready_o,
    output logic [15:0]        sample_out_o,
    output logic               sample_tick_o,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               underrun_o,
    input  logic               underrun_clr_i
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [15:0]        sample_q, sample_d;
    logic               tick_q, tick_d;
    logic               underrun_q, underrun_d;
    logic               last_b_q, last_b_d;

    logic               full_s;
    logic               empty_s;
    logic               grant_a_s;
    logic               grant_b_s;
    logic               push_s;
    logic [15:0]        push_data_s;
    logic               pop_evt_s;
    logic               pop_s;

    // Arbitration and divider event; full is judged on the pre-pop level
    always_comb begin
        full_s      = (level_q == LVL_FULL);
        empty_s     = (level_q == '0);
        grant_a_s   = rst_n & enable_i & ~full_s & a_valid_i & (~b_valid_i | last_b_q);
        grant_b_s   = rst_n & enable_i & ~full_s & b_valid_i & ~grant_a_s;
        push_s      = grant_a_s | grant_b_s;
        push_data_s = grant_a_s ? a_data_i : b_data_i;
        pop_evt_s   = enable_i & (cnt_q == CNT_LAST);
        pop_s       = pop_evt_s & ~empty_s;
    end

    // Next-state for divider, FIFO pointers, tick/sample and sticky underrun
    always_comb begin
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        sample_d   = sample_q;
        tick_d     = 1'b0;
        last_b_d   = last_b_q;
        underrun_d = underrun_q;

        if (pop_evt_s && empty_s) begin
            underrun_d = 1'b1;
        end else if (underrun_clr_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

        if (!enable_i) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            sample_d = 16'h0000;
            tick_d   = 1'b0;
        end else begin
            cnt_d  = pop_evt_s ? '0 : (cnt_q + CW'(1));
            tick_d = pop_evt_s;
            if (pop_evt_s) begin
                sample_d = empty_s ? 16'h0000 : mem_q[rd_ptr_q];
            end else begin
                sample_d = sample_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
                last_b_d = grant_b_s;
            end else begin
                wr_ptr_d = wr_ptr_q;
                last_b_d = last_b_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
                2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sample_q   <= 16'h0000;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            last_b_q   <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sample_q   <= sample_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            last_b_q   <= last_b_d;
        end
    end

    // FIFO storage; a flush only rewinds pointers, stale words are never read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign a_ready_o     = grant_a_s;
    assign b_ready_o     = grant_b_s;
    assign sample_out_o  = sample_q;
    assign sample_tick_o = tick_q;
    assign fifo_level_o  = level_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_audio_sample_sched.sv
// Randomized and directed bench for audio_sample_sched against a queue-based
// reference model (DIV=8, FIFO_AW=2).
module tb_audio_sample_sched;

    localparam int DIV   = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          a_valid_i;
    logic [15:0]   a_data_i;
    logic          a_ready_o;
    logic          b_valid_i;
    logic [15:0]   b_data_i;
    logic          b_ready_o;
    logic [15:0]   sample_out_o;
    logic          sample_tick_o;
    logic [AW:0]   fifo_level_o;
    logic          underrun_o;
    logic          underrun_clr_i;

    audio_sample_sched #(.DIV(DIV), .FIFO_AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .a_valid_i      (a_valid_i),
        .a_data_i       (a_data_i),
        .a_ready_o      (a_ready_o),
        .b_valid_i      (b_valid_i),
        .b_data_i       (b_data_i),
        .b_ready_o      (b_ready_o),
        .sample_out_o   (sample_out_o),
        .sample_tick_o  (sample_tick_o),
        .fifo_level_o   (fifo_level_o),
        .underrun_o     (underrun_o),
        .underrun_clr_i (underrun_clr_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mq [$];
    logic [15:0] seen [$];
    int          m_cnt;
    bit          m_last_b;
    logic [15:0] m_samp;
    bit          m_tick;
    bit          m_urn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt    = 0;
        m_last_b = 1'b1;
        m_samp   = 16'h0000;
        m_tick   = 1'b0;
        m_urn    = 1'b0;
    endtask

    // One clock: drive at negedge, check readies, advance model, check outputs
    task automatic cycle(input bit en, input bit av, input logic [15:0] ad,
                         input bit bv, input logic [15:0] bd, input bit clr);
        bit full, ga, gb, pop, was_empty;
        enable_i = en; a_valid_i = av; a_data_i = ad;
        b_valid_i = bv; b_data_i = bd; underrun_clr_i = clr;
        #1;
        full = (mq.size() == DEPTH);
        ga = en && !full && av && (!bv || m_last_b);
        gb = en && !full && bv && !ga;
        check_eq("a_ready", a_ready_o, ga);
        check_eq("b_ready", b_ready_o, gb);
        @(posedge clk);
        pop = en && (m_cnt == DIV - 1);
        was_empty = (mq.size() == 0);
        if (pop && was_empty) m_urn = 1'b1;
        else if (clr) m_urn = 1'b0;
        if (!en) begin
            mq.delete();
            m_cnt  = 0;
            m_samp = 16'h0000;
            m_tick = 1'b0;
        end else begin
            m_tick = pop;
            if (pop) m_samp = was_empty ? 16'h0000 : mq.pop_front();
            if (ga) begin mq.push_back(ad); m_last_b = 1'b0; end
            if (gb) begin mq.push_back(bd); m_last_b = 1'b1; end
            m_cnt = pop ? 0 : m_cnt + 1;
        end
        @(negedge clk);
        check_eq("sample_out", sample_out_o, m_samp);
        check_eq("sample_tick", sample_tick_o, m_tick);
        check_eq("fifo_level", fifo_level_o, mq.size());
        check_eq("underrun", underrun_o, m_urn);
        if (sample_tick_o) seen.push_back(sample_out_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; enable_i = 1'b1; a_valid_i = 1'b1; a_data_i = 16'h1234;
        b_valid_i = 1'b1; b_data_i = 16'h5678; underrun_clr_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_a_ready", a_ready_o, 1'b0);
        check_eq("rst_b_ready", b_ready_o, 1'b0);
        check_eq("rst_level", fifo_level_o, 3'd0);
        check_eq("rst_sample", sample_out_o, 16'h0000);
        check_eq("rst_tick", sample_tick_o, 1'b0);
        check_eq("rst_underrun", underrun_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // A pushes two words, three ticks follow (last one underruns)
        cycle(1'b1, 1'b1, 16'h1000, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h2000, 1'b0, 16'h0, 1'b0);
        idle(23);
        check_eq("s1_ticks", seen.size(), 3);
        if (seen.size() >= 3) begin
            check_eq("s1_first", seen[0], 16'h1000);
            check_eq("s1_second", seen[1], 16'h2000);
            check_eq("s1_third", seen[2], 16'h0000);
        end
        check_eq("s1_underrun", underrun_o, 1'b1);

        // Push into an empty FIFO on the pop cycle: no bypass
        while (m_cnt != DIV - 1) idle(1);
        cycle(1'b1, 1'b1, 16'h7FFF, 1'b0, 16'h0, 1'b0);
        check_eq("s4_tick", sample_tick_o, 1'b1);
        check_eq("s4_silence", sample_out_o, 16'h0000);
        idle(DIV);
        check_eq("s4_next", seen[$], 16'h7FFF);

        // Clear collides with a new underrun: set wins; plain clear works
        while (m_cnt != DIV - 1) idle(1);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        check_eq("s5_set_wins", underrun_o, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        check_eq("s5_cleared", underrun_o, 1'b0);

        // Both valid: alternate and fill; then B alone against a full FIFO
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 16'(16'hA000 + i), 1'b1, 16'(16'hB000 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1, 16'(16'hC000 + i), 1'b0);

        // Drop enable with level 3, then re-enable and time the first tick
        idle(40);
        while (m_cnt != 1) idle(1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'(16'h0100 + i), 1'b0, 16'h0, 1'b0);
        check_eq("s6_level3", fifo_level_o, 3'd3);
        cycle(1'b0, 1'b1, 16'h0999, 1'b0, 16'h0, 1'b0);
        check_eq("s6_flushed", fifo_level_o, 3'd0);
        check_eq("s6_sample0", sample_out_o, 16'h0000);
        check_eq("s6_no_tick", sample_tick_o, 1'b0);
        begin
            int  n = 0;
            bit  got = 1'b0;
            while (!got && n < 20) begin
                idle(1);
                n++;
                got = sample_tick_o;
            end
            check_eq("s6_reenable_period", n, DIV);
        end

        // Async reset mid-transfer discards everything
        cycle(1'b1, 1'b1, 16'h4444, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h5555, 1'b1, 16'h6666, 1'b0);
        a_valid_i = 1'b1; b_valid_i = 1'b1; enable_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_level", fifo_level_o, 3'd0);
        check_eq("arst_sample", sample_out_o, 16'h0000);
        check_eq("arst_a_ready", a_ready_o, 1'b0);
        check_eq("arst_underrun", underrun_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic: dense phase then sparse phase
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 16'($urandom),
                  ($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 15) == 0));
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) == 0), 16'($urandom),
                  ($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 15) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
